// File: rtl/alu_issue_ctrl.sv
// Issue controller for the datapath ALU: decodes ALUOp/funct, holds operands for a settle time, returns result.
// Optional issued-op counter enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_ctrl #(
  parameter int FAST_LAT   = 1,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [2:0]  alu_sel,
  input  logic [31:0] alu_rel,
  input  logic        alu_zf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zf,
  output logic [1:0]  err,
  output logic [31:0] issue_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam logic [2:0] SEL_ADD = 3'b111;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_MUL = 3'b100;
  localparam logic [2:0] SEL_DIV = 3'b000;
  localparam logic [2:0] SEL_AND = 3'b011;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_SLL = 3'b010;
  localparam logic [2:0] SEL_XOR = 3'b101;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;

  localparam logic [CNT_W-1:0] FAST_LOAD   = CNT_W'(FAST_LAT - 1);
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_LAT - 1);

  // Returns {illegal, select}; an illegal funct falls back to the add select.
  function automatic logic [3:0] decode_op(input logic [1:0] op, input logic [5:0] fn);
    logic [3:0] d;
    case (op)
      2'b00:   d = {1'b0, SEL_ADD};
      2'b01:   d = {1'b0, SEL_SUB};
      2'b11:   d = {1'b0, SEL_OR};
      2'b10: begin
        case (fn)
          6'b100000: d = {1'b0, SEL_ADD};
          6'b100010: d = {1'b0, SEL_SUB};
          6'b011000: d = {1'b0, SEL_MUL};
          6'b011010: d = {1'b0, SEL_DIV};
          6'b100100: d = {1'b0, SEL_AND};
          6'b100101: d = {1'b0, SEL_OR};
          6'b000000: d = {1'b0, SEL_SLL};
          6'b100110: d = {1'b0, SEL_XOR};
          default:   d = {1'b1, SEL_ADD};
        endcase
      end
      default: d = {1'b1, SEL_ADD};
    endcase
    return d;
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       dec_s;
  logic             illegal_s;
  logic [2:0]       dec_sel_s;
  logic             muldiv_s;
  logic             div0_s;
  logic             accept_s;

  // Decode the incoming request and classify it.
  always_comb begin
    dec_s     = decode_op(alu_op, funct);
    illegal_s = dec_s[3];
    dec_sel_s = dec_s[2:0];
    muldiv_s  = 1'b0;
    div0_s    = 1'b0;
    if (!illegal_s && ((dec_sel_s == SEL_MUL) || (dec_sel_s == SEL_DIV))) begin
      muldiv_s = 1'b1;
      div0_s   = (dec_sel_s == SEL_DIV) && (b_in == 32'd0);
    end else begin
      muldiv_s = 1'b0;
      div0_s   = 1'b0;
    end
  end

  assign accept_s = in_valid & in_ready;

  // Main FSM with registered handshake, ALU drive and capture outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= 32'd0;
      zf        <= 1'b0;
      err       <= ERR_OK;
      alu_op1   <= 32'd0;
      alu_op2   <= 32'd0;
      alu_sel   <= SEL_ADD;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            alu_op1  <= a_in;
            alu_op2  <= b_in;
            alu_sel  <= dec_sel_s;
            in_ready <= 1'b0;
            if (illegal_s) begin
              result    <= 32'd0;
              zf        <= 1'b0;
              err       <= ERR_ILLEGAL;
              out_valid <= 1'b1;
              state_r   <= DONE;
            end else if (div0_s) begin
              result    <= 32'hFFFF_FFFF;
              zf        <= 1'b0;
              err       <= ERR_DIV0;
              out_valid <= 1'b1;
              state_r   <= DONE;
            end else begin
              cnt_r   <= muldiv_s ? MULDIV_LOAD : FAST_LOAD;
              state_r <= SETTLE;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
          end else begin
            result    <= alu_rel;
            zf        <= alu_zf;
            err       <= ERR_OK;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] issue_cnt_r;

  // Count every accepted request, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_r <= 32'd0;
    end else if (accept_s) begin
      issue_cnt_r <= issue_cnt_r + 32'd1;
    end else begin
      issue_cnt_r <= issue_cnt_r;
    end
  end

  assign issue_cnt = issue_cnt_r;
`else
  assign issue_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_sel;
  logic [31:0] alu_rel;
  logic        alu_zf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zf;
  logic [1:0]  err;
  logic [31:0] issue_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;
  logic [31:0] exp_cnt;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .a_in(a_in), .b_in(b_in),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_rel(alu_rel), .alu_zf(alu_zf), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zf(zf), .err(err),
    .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU driven by the controller's select and operands.
  always_comb begin
    case (alu_sel)
      3'b111:  alu_rel = alu_op1 + alu_op2;
      3'b110:  alu_rel = alu_op1 - alu_op2;
      3'b100:  alu_rel = alu_op1 * alu_op2;
      3'b000:  alu_rel = (alu_op2 != 32'd0) ? alu_op1 / alu_op2 : 32'd0;
      3'b011:  alu_rel = alu_op1 & alu_op2;
      3'b001:  alu_rel = alu_op1 | alu_op2;
      3'b010:  alu_rel = alu_op1 << alu_op2[4:0];
      3'b101:  alu_rel = alu_op1 ^ alu_op2;
      default: alu_rel = 32'd0;
    endcase
    alu_zf = (alu_rel == 32'd0);
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic accept(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
    int n;
    alu_op = op; funct = fn; a_in = a; b_in = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk_eq("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in = 32'hDEAD_BEEF; b_in = 32'hDEAD_BEEF;
  endtask

  task automatic wait_out(output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!out_valid && l < 30);
    if (!out_valid) chk_eq("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk_eq({tag, "_ov_clear"}, {31'd0, out_valid}, 32'd0);
    chk_eq({tag, "_ir_set"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; funct = 6'd0; a_in = 32'd0; b_in = 32'd0;
    repeat (2) @(negedge clk);
    chk_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_eq("rst_result", result, 32'd0);
    chk_eq("rst_zf_err", {29'd0, zf, err}, 32'd0);
    chk_eq("rst_sel", {29'd0, alu_sel}, 32'd7);
    chk_eq("rst_op1", alu_op1, 32'd0);
    chk_eq("rst_op2", alu_op2, 32'd0);
    chk_eq("rst_cnt", issue_cnt, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // add 5 + 7
    accept(2'b00, 6'd0, 32'd5, 32'd7);
    chk_eq("add_sel", {29'd0, alu_sel}, 32'd7);
    chk_eq("add_in_ready", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    chk_eq("add_lat", lat, 32'd2);
    chk_eq("add_result", result, 32'd12);
    chk_eq("add_err", {30'd0, err}, 32'd0);
    take("add");

    // mul 6 * 7 via funct
    accept(2'b10, 6'b011000, 32'd6, 32'd7);
    chk_eq("mul_sel", {29'd0, alu_sel}, 32'd4);
    chk_eq("mul_op1", alu_op1, 32'd6);
    chk_eq("mul_op2", alu_op2, 32'd7);
    wait_out(lat);
    chk_eq("mul_lat", lat, 32'd5);
    chk_eq("mul_sel_held", {29'd0, alu_sel}, 32'd4);
    chk_eq("mul_result", result, 32'd42);
    chk_eq("mul_err", {30'd0, err}, 32'd0);
    take("mul");

    // div by zero short-circuits the ALU
    accept(2'b10, 6'b011010, 32'd9, 32'd0);
    chk_eq("div0_sel", {29'd0, alu_sel}, 32'd0);
    wait_out(lat);
    chk_eq("div0_lat", lat, 32'd1);
    chk_eq("div0_result", result, 32'hFFFF_FFFF);
    chk_eq("div0_err", {30'd0, err}, 32'd2);
    chk_eq("div0_zf", {31'd0, zf}, 32'd0);
    take("div0");

    // illegal funct, then consumer stalls three cycles
    accept(2'b10, 6'b111111, 32'd3, 32'd4);
    wait_out(lat);
    chk_eq("ill_lat", lat, 32'd1);
    chk_eq("ill_err", {30'd0, err}, 32'd1);
    chk_eq("ill_result", result, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("stall_ov", {31'd0, out_valid}, 32'd1);
      chk_eq("stall_result", result, 32'd0);
      chk_eq("stall_err", {30'd0, err}, 32'd1);
      chk_eq("stall_ir", {31'd0, in_ready}, 32'd0);
    end
    take("ill");

    // reset during mul settle discards the op
    accept(2'b10, 6'b011000, 32'd3, 32'd3);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_eq("mrst_ov", {31'd0, out_valid}, 32'd0);
    chk_eq("mrst_ir", {31'd0, in_ready}, 32'd1);
    chk_eq("mrst_sel", {29'd0, alu_sel}, 32'd7);
    chk_eq("mrst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_eq("mrst_no_out", {31'd0, out_valid}, 32'd0);

    accept(2'b00, 6'd0, 32'd1, 32'd1);
    wait_out(lat);
    chk_eq("post_add_lat", lat, 32'd2);
    chk_eq("post_add_result", result, 32'd2);
    take("post_add");

    // sub yielding zero exercises the zero flag capture
    accept(2'b01, 6'd0, 32'd5, 32'd5);
    chk_eq("sub_sel", {29'd0, alu_sel}, 32'd6);
    wait_out(lat);
    chk_eq("sub_result", result, 32'd0);
    chk_eq("sub_zf", {31'd0, zf}, 32'd1);
    take("sub");

    accept(2'b10, 6'b100110, 32'h0000_F0F0, 32'h0000_0FF0);
    chk_eq("xor_sel", {29'd0, alu_sel}, 32'd5);
    wait_out(lat);
    chk_eq("xor_result", result, 32'h0000_FF00);
    chk_eq("xor_zf", {31'd0, zf}, 32'd0);
    take("xor");

`ifdef ALU_ISSUE_PERF_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    chk_eq("issue_cnt_3", issue_cnt, exp_cnt);

`ifdef ALU_ISSUE_PERF_EN
    force dut.issue_cnt_r = 32'hFFFF_FFFF;
    #1;
    release dut.issue_cnt_r;
    @(negedge clk);
    chk_eq("issue_cnt_pre", issue_cnt, 32'hFFFF_FFFF);
`endif

    accept(2'b11, 6'd0, 32'h0000_0010, 32'h0000_0001);
    chk_eq("or_sel", {29'd0, alu_sel}, 32'd1);
    wait_out(lat);
    chk_eq("or_result", result, 32'h0000_0011);
    take("or");
    chk_eq("issue_cnt_wrap", issue_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential front end for the datapath ALU.
- Accepts ALUOp/funct plus two 32-bit operands over a valid/ready handshake and decodes them into the ALU's 3-bit select.
- Holds the ALU inputs stable for an op-dependent settle time, then captures the ALU result and zero flag and returns them over a second valid/ready handshake.
- Sits between the decode/register-read stage and the ALU; this is the consumer end of the ALU select/result interface.

Parameters:
- FAST_LAT, 1, settle cycles for add/sub/and/or/sll/xor (min 1).
- MULDIV_LAT, 4, settle cycles for mul/div (min 1).
- CNT_W, 3, width of settle counter; must hold max(FAST_LAT, MULDIV_LAT).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  controller can accept a request.
- alu_op  input  2  00 add, 01 sub, 10 R-type (use funct), 11 or.
- funct  input  6  R-type function field.
- a_in  input  32  operand 1.
- b_in  input  32  operand 2.
- alu_op1  output  32  to ALU op1.
- alu_op2  output  32  to ALU op2.
- alu_sel  output  3  to ALU sel.
- alu_rel  input  32  ALU result.
- alu_zf  input  1  ALU zeroflag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  32  captured result.
- zf  output  1  captured ALU zeroflag, passed through uninterpreted.
- err  output  2  00 ok, 01 illegal funct, 10 divide by zero.
- issue_cnt  output  32  issued-op counter (see Optional Feature).

Behaviour:
- Select codes: add 111, sub 110, mul 100, div 000, and 011, or 001, sll 010, xor 101.
- Funct decode (alu_op=10): 100000 add, 100010 sub, 011000 mul, 011010 div, 100100 and, 100101 or, 000000 sll, 100110 xor. Any other funct is illegal.
- Reset values: in_ready=1, out_valid=0, result=0, zf=0, err=00, alu_op1=0, alu_op2=0, alu_sel=111, issue_cnt=0, state=IDLE, counter=0.
- FSM states: IDLE, SETTLE, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready, latch a_in/b_in into alu_op1/alu_op2 and the decoded code into alu_sel.
  - Illegal funct: skip the ALU, go to DONE with result=0, zf=0, err=01.
  - Div with b_in==0: skip the ALU, go to DONE with result=32'hFFFFFFFF, zf=0, err=10.
  - Otherwise load the counter with FAST_LAT-1 or MULDIV_LAT-1 and go to SETTLE.
- SETTLE: in_ready=0; ALU inputs held stable.
  - While counter!=0, decrement.
  - When counter==0, capture alu_rel into result and alu_zf into zf, set err=00, and go to DONE.
  - Latency accept-to-out_valid: lat+1 cycles (2 for fast ops at default, 5 for mul/div).
- DONE: out_valid=1; result/zf/err held stable until out_valid&out_ready.
  - On that handshake: out_valid=0, in_ready=1 next cycle, go to IDLE. No same-cycle back-to-back accept.
- Output stability: ALU inputs are registered and change only on an IDLE accept. result, zf and err change only on capture.
- in_valid while in_ready=0 is ignored; the requester holds it.
- out_ready with out_valid=0 has no effect.
- rst_n low mid-operation: immediate return to reset values; the in-flight op is discarded, no output.
- Arithmetic belongs to the ALU; this block does no width math apart from the b_in==0 compare.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Defined: issue_cnt increments by 1 on every accepted request (legal, illegal and div-by-zero alike) and wraps 32'hFFFFFFFF->0.
- Undefined: issue_cnt is tied to 0 and no counter flops exist. All other behaviour is identical.

Test Plan:
- Reset, then alu_op=00, a=5, b=7 -> alu_sel=111; out_valid 2 cycles after accept; result=12 (model ALU); err=00.
- alu_op=10, funct=011000, a=6, b=7 -> alu_sel=100 held 4 cycles; result=42 at cycle 5.
- alu_op=10, funct=011010, a=9, b=0 -> out_valid next cycle; result=FFFFFFFF; err=10; alu_rel ignored.
- alu_op=10, funct=111111 -> err=01, result=0; then hold out_ready=0 for 3 cycles -> out_valid/result stable and in_ready=0 throughout.
- Assert rst_n=0 during SETTLE of a mul -> out_valid=0, in_ready=1, no result issued; next add a=1, b=1 returns 2.
- With ALU_ISSUE_PERF_EN: 3 accepted ops -> issue_cnt=3. Preload to FFFFFFFF by force, one more accept -> 0. Without the macro, issue_cnt=0 throughout.
